// File: rtl/gmii_tx_arbiter.sv
// Two-source GMII transmit scheduler: round-robin grant, start strobe, registered
// datapath, inter-frame gap, start-timeout and overlong-frame recovery.
module gmii_tx_arbiter #(
   parameter int unsigned IFG_CYCLES       = 12,
   parameter int unsigned START_TIMEOUT    = 16,
   parameter int unsigned MAX_FRAME_CYCLES = 1530
) (
   input  logic       clk,
   input  logic       RSTn,
   input  logic [1:0] req,
   output logic [1:0] start,
   input  logic       src0_tx_en,
   input  logic [7:0] src0_data,
   input  logic       src1_tx_en,
   input  logic [7:0] src1_data,
   output logic       gmii_tx_en,
   output logic [7:0] gmii_txd,
   output logic [1:0] grant,
   output logic       busy,
   output logic       timeout_err,
   output logic       overlong_err
);

   localparam int unsigned CNT_W = 8;
   localparam int unsigned FRM_W = $clog2(MAX_FRAME_CYCLES + 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WAIT  = 3'd1;
   localparam logic [2:0] S_XMIT  = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_GAP   = 3'd4;

   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(START_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(IFG_CYCLES - 1);
   localparam logic [FRM_W-1:0] FRM_MAX   = FRM_W'(MAX_FRAME_CYCLES);

   logic [2:0]       state, state_nxt;
   logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
   logic [CNT_W-1:0] gap_cnt, gap_cnt_nxt;
   logic [FRM_W-1:0] frame_cnt, frame_cnt_nxt;
   logic             last_grant, last_grant_nxt;
   logic [1:0]       start_nxt, grant_nxt;
   logic             tx_en_nxt, busy_nxt, timeout_nxt, overlong_nxt;
   logic [7:0]       txd_nxt;
   logic             win_c;
   logic             sel_tx_en_c;
   logic [7:0]       sel_data_c;

   // Only the granted source is ever looked at
   always_comb begin
      sel_tx_en_c = 1'b0;
      sel_data_c  = 8'h00;
      if (grant[0]) begin
         sel_tx_en_c = src0_tx_en;
         sel_data_c  = src0_data;
      end else if (grant[1]) begin
         sel_tx_en_c = src1_tx_en;
         sel_data_c  = src1_data;
      end
   end

   always_comb begin
      state_nxt      = state;
      wait_cnt_nxt   = wait_cnt;
      gap_cnt_nxt    = gap_cnt;
      frame_cnt_nxt  = frame_cnt;
      last_grant_nxt = last_grant;
      grant_nxt      = grant;
      start_nxt      = 2'b00;
      tx_en_nxt      = 1'b0;
      txd_nxt        = 8'h00;
      timeout_nxt    = 1'b0;
      overlong_nxt   = 1'b0;
      win_c          = 1'b0;

      case (state)
         S_IDLE: begin
            wait_cnt_nxt  = '0;
            gap_cnt_nxt   = '0;
            frame_cnt_nxt = '0;
            grant_nxt     = 2'b00;
            if (req != 2'b00) begin
               // On a tie the source not served last wins
               case (req)
                  2'b01:   win_c = 1'b0;
                  2'b10:   win_c = 1'b1;
                  default: win_c = ~last_grant;
               endcase
               grant_nxt      = win_c ? 2'b10 : 2'b01;
               start_nxt      = win_c ? 2'b10 : 2'b01;
               last_grant_nxt = win_c;
               state_nxt      = S_WAIT;
            end
         end

         S_WAIT: begin
            if (sel_tx_en_c) begin
               tx_en_nxt     = 1'b1;
               txd_nxt       = sel_data_c;
               frame_cnt_nxt = FRM_W'(1);
               wait_cnt_nxt  = '0;
               state_nxt     = S_XMIT;
            end else if (wait_cnt == WAIT_LAST) begin
               timeout_nxt  = 1'b1;
               grant_nxt    = 2'b00;
               wait_cnt_nxt = '0;
               gap_cnt_nxt  = '0;
               state_nxt    = S_GAP;
            end else begin
               wait_cnt_nxt = wait_cnt + CNT_W'(1);
            end
         end

         S_XMIT: begin
            if (!sel_tx_en_c) begin
               grant_nxt   = 2'b00;
               gap_cnt_nxt = '0;
               state_nxt   = S_GAP;
            end else if (frame_cnt == FRM_MAX) begin
               overlong_nxt = 1'b1;
               state_nxt    = S_DRAIN;
            end else begin
               tx_en_nxt     = 1'b1;
               txd_nxt       = sel_data_c;
               frame_cnt_nxt = frame_cnt + FRM_W'(1);
            end
         end

         S_DRAIN: begin
            if (!sel_tx_en_c) begin
               grant_nxt   = 2'b00;
               gap_cnt_nxt = '0;
               state_nxt   = S_GAP;
            end
         end

         S_GAP: begin
            grant_nxt = 2'b00;
            if (gap_cnt == GAP_LAST) begin
               gap_cnt_nxt = '0;
               state_nxt   = S_IDLE;
            end else begin
               gap_cnt_nxt = gap_cnt + CNT_W'(1);
            end
         end

         default: begin
            grant_nxt = 2'b00;
            state_nxt = S_IDLE;
         end
      endcase

      busy_nxt = (state_nxt != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!RSTn) begin
         state        <= S_IDLE;
         wait_cnt     <= '0;
         gap_cnt      <= '0;
         frame_cnt    <= '0;
         last_grant   <= 1'b1;
         start        <= 2'b00;
         grant        <= 2'b00;
         gmii_tx_en   <= 1'b0;
         gmii_txd     <= 8'h00;
         busy         <= 1'b0;
         timeout_err  <= 1'b0;
         overlong_err <= 1'b0;
      end else begin
         state        <= state_nxt;
         wait_cnt     <= wait_cnt_nxt;
         gap_cnt      <= gap_cnt_nxt;
         frame_cnt    <= frame_cnt_nxt;
         last_grant   <= last_grant_nxt;
         start        <= start_nxt;
         grant        <= grant_nxt;
         gmii_tx_en   <= tx_en_nxt;
         gmii_txd     <= txd_nxt;
         busy         <= busy_nxt;
         timeout_err  <= timeout_nxt;
         overlong_err <= overlong_nxt;
      end
   end

endmodule

// File: tb/tb_gmii_tx_arbiter.sv
// Scoreboard bench for gmii_tx_arbiter: stimulus queues expected bytes, grants and
// error pulses; a negedge monitor pops and compares whatever the DUT presents.
module tb_gmii_tx_arbiter;

   localparam int unsigned IFG  = 12;
   localparam int unsigned TOUT = 16;
   localparam int unsigned MAXF = 1530;

   logic       clk = 1'b0;
   logic       RSTn;
   logic [1:0] req;
   logic [1:0] start;
   logic       src0_tx_en, src1_tx_en;
   logic [7:0] src0_data, src1_data;
   logic       gmii_tx_en;
   logic [7:0] gmii_txd;
   logic [1:0] grant;
   logic       busy, timeout_err, overlong_err;

   gmii_tx_arbiter #(
      .IFG_CYCLES(IFG), .START_TIMEOUT(TOUT), .MAX_FRAME_CYCLES(MAXF)
   ) dut (
      .clk(clk), .RSTn(RSTn), .req(req), .start(start),
      .src0_tx_en(src0_tx_en), .src0_data(src0_data),
      .src1_tx_en(src1_tx_en), .src1_data(src1_data),
      .gmii_tx_en(gmii_tx_en), .gmii_txd(gmii_txd), .grant(grant),
      .busy(busy), .timeout_err(timeout_err), .overlong_err(overlong_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { logic [7:0] d; int cyc; } byte_t;
   byte_t      byte_q[$];
   logic [1:0] start_q[$];
   int         err_q[$];
   string      chk_name[$];
   int         chk_act[$];
   int         chk_exp[$];

   int n_checks = 0;
   int n_fails  = 0;

   // Monitor-side observations used by directed timing checks
   int fall_cyc = -1, to_cyc = -1, ov_cyc = -1, busy_fall_cyc = -1;
   int run = 0, last_run = 0;
   logic prev_busy = 1'b0, prev_tx_en = 1'b0;

   task automatic expect_eq(input string name, input int act, input int exp);
      chk_name.push_back(name);
      chk_act.push_back(act);
      chk_exp.push_back(exp);
   endtask

   // Monitor: sole owner of the pass/fail counters
   initial begin
      byte_t      b;
      logic [1:0] es;
      int         ee;
      forever begin
         @(negedge clk);
         n_checks++;
         if (gmii_tx_en) begin
            run++;
            if (byte_q.size() == 0) begin
               n_fails++;
               $display("FAIL txd_extra: got %02h at cycle %0d, no byte expected", gmii_txd, cyc);
            end else begin
               b = byte_q.pop_front();
               if (gmii_txd !== b.d || cyc != b.cyc) begin
                  n_fails++;
                  $display("FAIL txd: got %02h at cycle %0d, expected %02h at cycle %0d",
                           gmii_txd, cyc, b.d, b.cyc);
               end
            end
         end else begin
            if (gmii_txd !== 8'h00) begin
               n_fails++;
               $display("FAIL txd_idle: got %02h, expected 00 at cycle %0d", gmii_txd, cyc);
            end
            if (prev_tx_en) begin
               fall_cyc = cyc;
               last_run = run;
            end
            run = 0;
         end

         if (start !== 2'b00) begin
            n_checks += 3;
            if (start_q.size() == 0) begin
               n_fails++;
               $display("FAIL start_extra: got %b at cycle %0d, none expected", start, cyc);
            end else begin
               es = start_q.pop_front();
               if (start !== es) begin
                  n_fails++;
                  $display("FAIL start: got %b, expected %b at cycle %0d", start, es, cyc);
               end
            end
            if (grant !== start) begin
               n_fails++;
               $display("FAIL grant: got %b, expected %b at cycle %0d", grant, start, cyc);
            end
            if (prev_busy) begin
               n_fails++;
               $display("FAIL start_busy: start %b while busy the cycle before, cycle %0d", start, cyc);
            end
         end

         if (timeout_err || overlong_err) begin
            n_checks++;
            ee = timeout_err ? 1 : 2;
            if (ee == 1) to_cyc = cyc; else ov_cyc = cyc;
            if (err_q.size() == 0) begin
               n_fails++;
               $display("FAIL err_extra: got err %0d at cycle %0d, none expected", ee, cyc);
            end else if (err_q.pop_front() != ee) begin
               n_fails++;
               $display("FAIL err_kind: got err %0d at cycle %0d, other kind expected", ee, cyc);
            end
         end

         if (!busy && prev_busy) busy_fall_cyc = cyc;
         prev_busy  = busy;
         prev_tx_en = gmii_tx_en;

         while (chk_name.size() != 0) begin
            string nm;
            int    a, e;
            nm = chk_name.pop_front();
            a  = chk_act.pop_front();
            e  = chk_exp.pop_front();
            n_checks++;
            if (a != e) begin
               n_fails++;
               $display("FAIL %s: got %0d, expected %0d", nm, a, e);
            end
         end
      end
   end

   task automatic wait_start(input int s, output int at);
      bit seen = 1'b0;
      at = -1;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         if (start[s]) begin
            seen = 1'b1;
            at   = cyc;
         end
      end
      if (!seen) expect_eq($sformatf("start%0d_wait", s), 0, 1);
   endtask

   task automatic wait_idle();
      bit done = 1'b0;
      for (int i = 0; i < 3000 && !done; i++) begin
         @(negedge clk);
         if (!busy) done = 1'b1;
      end
      if (!done) expect_eq("idle_wait", 0, 1);
      @(negedge clk);
   endtask

   // Drives n bytes (preamble 55x7, D5, then base+i); only the first fwd are expected out
   task automatic drive_frame(input int s, input int n, input int fwd, input int base,
                              output int last_cyc);
      logic [7:0] d;
      last_cyc = cyc;
      for (int i = 0; i < n; i++) begin
         d = (i < 7) ? 8'h55 : (i == 7) ? 8'hD5 : 8'(base + i);
         if (s == 0) begin src0_tx_en = 1'b1; src0_data = d; end
         else        begin src1_tx_en = 1'b1; src1_data = d; end
         if (i < fwd) byte_q.push_back('{d: d, cyc: cyc + 1});
         last_cyc = cyc;
         @(negedge clk);
      end
      if (s == 0) begin src0_tx_en = 1'b0; src0_data = 8'h00; end
      else        begin src1_tx_en = 1'b0; src1_data = 8'h00; end
   endtask

   task automatic pulse_reset();
      RSTn = 1'b0;
      repeat (2) @(negedge clk);
      RSTn = 1'b1;
   endtask

   initial begin
      int t0, t1, lc;
      logic [7:0] d;
      RSTn = 1'b0; req = 2'b00;
      src0_tx_en = 1'b0; src1_tx_en = 1'b0; src0_data = 8'h00; src1_data = 8'h00;

      // Reset values
      @(negedge clk);
      expect_eq("rst_gmii_tx_en", int'(gmii_tx_en), 0);
      expect_eq("rst_gmii_txd", int'(gmii_txd), 0);
      expect_eq("rst_grant", int'(grant), 0);
      expect_eq("rst_start", int'(start), 0);
      expect_eq("rst_busy", int'(busy), 0);
      expect_eq("rst_timeout_err", int'(timeout_err), 0);
      expect_eq("rst_overlong_err", int'(overlong_err), 0);
      @(negedge clk);
      RSTn = 1'b1;
      repeat (2) @(negedge clk);

      // Single 72-byte frame from source 0, tx_en two cycles after start
      start_q.push_back(2'b01);
      req = 2'b01;
      wait_start(0, t0);
      req = 2'b00;
      repeat (2) @(negedge clk);
      drive_frame(0, 72, 72, 8'h10, lc);
      wait_idle();
      expect_eq("single_len", last_run, 72);

      // Simultaneous requests after reset; source 1 junk ignored? no: source 0 junk while 1 owns
      pulse_reset();
      @(negedge clk);
      start_q.push_back(2'b01);
      start_q.push_back(2'b10);
      req = 2'b11;
      wait_start(0, t0);
      req = 2'b10;
      @(negedge clk);
      drive_frame(0, 20, 20, 8'h40, lc);
      wait_start(1, t1);
      expect_eq("tie_gap", t1 - fall_cyc, int'(IFG) + 1);
      req = 2'b00;
      src0_tx_en = 1'b1; src0_data = 8'hEE;
      @(negedge clk);
      drive_frame(1, 10, 10, 8'h80, lc);
      src0_tx_en = 1'b0; src0_data = 8'h00;
      wait_idle();
      expect_eq("tie_len1", last_run, 10);

      // Fairness: req=11 held across 6 frames
      for (int k = 0; k < 6; k++) start_q.push_back((k % 2 == 0) ? 2'b01 : 2'b10);
      req = 2'b11;
      for (int k = 0; k < 6; k++) begin
         wait_start(k % 2, t0);
         if (k == 5) req = 2'b00;
         @(negedge clk);
         drive_frame(k % 2, 8, 8, 8'h20 * k, lc);
      end
      wait_idle();

      // Start timeout on source 1 with source 0 pending
      start_q.push_back(2'b10);
      start_q.push_back(2'b01);
      err_q.push_back(1);
      req = 2'b10;
      wait_start(1, t1);
      req = 2'b01;
      wait_start(0, t0);
      expect_eq("timeout_delay", to_cyc - t1, int'(TOUT));
      expect_eq("timeout_gap", t0 - to_cyc, int'(IFG) + 1);
      req = 2'b00;
      @(negedge clk);
      drive_frame(0, 5, 5, 8'hA0, lc);
      wait_idle();
      expect_eq("after_timeout_len", last_run, 5);

      // Overlong 1600-cycle frame truncated at the cap
      start_q.push_back(2'b01);
      err_q.push_back(2);
      req = 2'b01;
      wait_start(0, t0);
      req = 2'b00;
      drive_frame(0, 1600, int'(MAXF), 8'h00, lc);
      wait_idle();
      expect_eq("overlong_len", last_run, int'(MAXF));
      expect_eq("overlong_pulse_at_fall", ov_cyc, fall_cyc);
      expect_eq("drain_then_gap", busy_fall_cyc - lc, int'(IFG) + 2);

      // Reset in the middle of a frame at byte 30
      start_q.push_back(2'b01);
      req = 2'b01;
      wait_start(0, t0);
      req = 2'b00;
      for (int i = 0; i < 41; i++) begin
         if (i == 31) begin
            expect_eq("midrst_gmii_tx_en", int'(gmii_tx_en), 0);
            expect_eq("midrst_grant", int'(grant), 0);
            expect_eq("midrst_busy", int'(busy), 0);
            RSTn = 1'b1;
         end
         d = 8'(8'hC0 + i);
         src0_tx_en = 1'b1; src0_data = d;
         if (i < 30) byte_q.push_back('{d: d, cyc: cyc + 1});
         if (i == 30) RSTn = 1'b0;
         @(negedge clk);
      end
      src0_tx_en = 1'b0; src0_data = 8'h00;
      repeat (2) @(negedge clk);
      start_q.push_back(2'b01);
      req = 2'b11;
      wait_start(0, t0);
      req = 2'b00;
      @(negedge clk);
      drive_frame(0, 4, 4, 8'h33, lc);
      wait_idle();

      expect_eq("bytes_left", byte_q.size(), 0);
      expect_eq("starts_left", start_q.size(), 0);
      expect_eq("errs_left", err_q.size(), 0);
      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
